// File: rtl/lut_and_vec_pkg.sv
// Shared types and constants for the AND-vector driver.
// Optional feature: LUT_AND_VEC_LFSR_EN selects an LFSR vector source.
package lut_and_vec_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DRIVE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic [7:0]  VEC_A0     = 8'd9;
  localparam logic [7:0]  VEC_B0     = 8'd15;
  localparam logic [7:0]  VEC_A_STEP = 8'd37;
  localparam logic [7:0]  VEC_B_STEP = 8'd29;
  localparam logic [15:0] LFSR_SEED  = 16'hACE1;

`ifdef LUT_AND_VEC_LFSR_EN
  // Fibonacci step, taps 16,14,13,11; feedback enters at the LSB.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction
`endif

endpackage

// File: rtl/lut_and_vec_src.sv
// Vector source: running adders by default, 16-bit LFSR when
// LUT_AND_VEC_LFSR_EN is defined. load rewinds to vector 0,
// advance steps to the next vector.
module lut_and_vec_src
  import lut_and_vec_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       load,
  input  logic       advance,
  output logic [7:0] a,
  output logic [7:0] b
);

`ifdef LUT_AND_VEC_LFSR_EN
  logic [15:0] lfsr;

  // LFSR reseeds on reset/start and shifts once per check.
  always_ff @(posedge clock) begin
    if (reset || load) lfsr <= LFSR_SEED;
    else if (advance)  lfsr <= lfsr_step(lfsr);
  end

  assign a = lfsr[15:8];
  assign b = lfsr[7:0];
`else
  logic [7:0] acc_a;
  logic [7:0] acc_b;

  // Arithmetic sequences; mod-256 wrap comes free from the 8-bit adders.
  always_ff @(posedge clock) begin
    if (reset || load) begin
      acc_a <= VEC_A0;
      acc_b <= VEC_B0;
    end else if (advance) begin
      acc_a <= acc_a + VEC_A_STEP;
      acc_b <= acc_b + VEC_B_STEP;
    end
  end

  assign a = acc_a;
  assign b = acc_b;
`endif

endmodule

// File: rtl/lut_and_vec_driver_i8.sv
// Drives a/b vectors into an 8-bit AND DUT, waits LATENCY cycles,
// checks y == a & b and reports err_count / fail_idx / pass.
// Optional feature: LUT_AND_VEC_LFSR_EN (see lut_and_vec_src).
//
//  state | meaning
//  IDLE  | after reset, waiting for start
//  DRIVE | register vector idx onto a/b
//  WAIT  | let the DUT settle, LATENCY cycles (down-counter)
//  CHECK | compare y against a & b, step idx
//  DONE  | results held until next start
module lut_and_vec_driver_i8
  import lut_and_vec_pkg::*;
#(
  parameter int NUM_VEC = 16,
  parameter int LATENCY = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  output logic [7:0] a,
  output logic [7:0] b,
  input  logic [7:0] y,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] err_count,
  output logic [7:0] fail_idx
);

  localparam logic [8:0] IDX_LAST  = 9'(NUM_VEC - 1);
  localparam logic [3:0] WAIT_LOAD = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  state_t     state;
  state_t     state_nxt;
  logic [8:0] idx;
  logic [3:0] wait_cnt;
  logic [7:0] src_a;
  logic [7:0] src_b;
  logic       start_ok;
  logic       mismatch;

  assign start_ok = start && ((state == ST_IDLE) || (state == ST_DONE));
  assign mismatch = (y != (a & b));

  lut_and_vec_src u_src (
    .clock   (clock),
    .reset   (reset),
    .load    (start_ok),
    .advance (state == ST_CHECK),
    .a       (src_a),
    .b       (src_b)
  );

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start) state_nxt = ST_DRIVE;
      ST_DRIVE: state_nxt = (LATENCY > 0) ? ST_WAIT : ST_CHECK;
      ST_WAIT:  if (wait_cnt == 4'd0) state_nxt = ST_CHECK;
      ST_CHECK: state_nxt = (idx == IDX_LAST) ? ST_DONE : ST_DRIVE;
      ST_DONE:  if (start) state_nxt = ST_DRIVE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Vector registers, wait timer, index and error bookkeeping.
  always_ff @(posedge clock) begin
    if (reset) begin
      idx       <= '0;
      a         <= '0;
      b         <= '0;
      wait_cnt  <= '0;
      err_count <= '0;
      fail_idx  <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            idx       <= '0;
            err_count <= '0;
            fail_idx  <= '0;
          end
        end
        ST_DRIVE: begin
          a        <= src_a;
          b        <= src_b;
          wait_cnt <= WAIT_LOAD;
        end
        ST_WAIT: begin
          if (wait_cnt != 4'd0) wait_cnt <= wait_cnt - 4'd1;
        end
        ST_CHECK: begin
          if (mismatch) begin
            // err_count never returns to zero once bumped, so it marks "first".
            if (err_count == 8'd0)   fail_idx  <= idx[7:0];
            if (err_count != 8'hFF)  err_count <= err_count + 8'd1;
          end
          if (idx != IDX_LAST) idx <= idx + 9'd1;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state == ST_DRIVE) || (state == ST_WAIT) || (state == ST_CHECK);
  assign done = (state == ST_DONE);
  assign pass = done && (err_count == 8'd0);

endmodule

// File: tb/tb_lut_and_vec_driver_i8.sv
// Bench for lut_and_vec_driver_i8: three instances (16/1, 256/1, 1/0),
// behavioural reference for the 16-vector instance plus literal checks.
module tb_lut_and_vec_driver_i8;

  localparam int NV  = 16;
  localparam int LAT = 1;
  localparam int PER = LAT + 2;
  localparam int TOT = NV * PER;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic start256 = 1'b0;
  logic start1 = 1'b0;
  int   mode = 0;

  logic [7:0] a, b, y, err_count, fail_idx;
  logic       busy, done, pass;
  logic [7:0] a2, b2, y2, err2, fidx2;
  logic       busy2, done2, pass2;
  logic [7:0] a3, b3, y3, err3, fidx3;
  logic       busy3, done3, pass3;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  // DUT behaviour by mode: 0 ideal, 1 stuck at 0, 2 fault at (194,160), 3 inverted
  function automatic logic [7:0] dut_resp(input int md, input logic [7:0] ia, input logic [7:0] ib);
    case (md)
      0: return ia & ib;
      1: return 8'd0;
      2: return (ia == 8'd194 && ib == 8'd160) ? 8'd0 : (ia & ib);
      default: return ~(ia & ib);
    endcase
  endfunction

`ifdef LUT_AND_VEC_LFSR_EN
  function automatic logic [15:0] lfsr_at(input int k);
    logic [15:0] s;
    s = 16'hACE1;
    for (int i = 0; i < k; i++) s = (s << 1) | 16'((s >> 15) ^ (s >> 13) ^ (s >> 12) ^ (s >> 10)) & 16'h1 | (s << 1);
    return s;
  endfunction
  function automatic logic [7:0] vec_a(input int k);
    logic [15:0] s;
    s = lfsr_at(k);
    return s[15:8];
  endfunction
  function automatic logic [7:0] vec_b(input int k);
    logic [15:0] s;
    s = lfsr_at(k);
    return s[7:0];
  endfunction
`else
  function automatic logic [7:0] vec_a(input int k);
    return 8'((9 + 37 * k) % 256);
  endfunction
  function automatic logic [7:0] vec_b(input int k);
    return 8'((15 + 29 * k) % 256);
  endfunction
`endif

  // Expected results of a whole run from the vector sequence and DUT behaviour.
  function automatic void exp_run(input int md, input int nv, output int err, output int fidx);
    logic [7:0] ea, eb;
    err  = 0;
    fidx = 0;
    for (int k = 0; k < nv; k++) begin
      ea = vec_a(k);
      eb = vec_b(k);
      if (dut_resp(md, ea, eb) != (ea & eb)) begin
        if (err == 0) fidx = k;
        if (err < 255) err++;
      end
    end
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  lut_and_vec_driver_i8 #(.NUM_VEC(NV), .LATENCY(LAT)) dut (
    .clock(clock), .reset(reset), .start(start), .a(a), .b(b), .y(y),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count), .fail_idx(fail_idx)
  );

  lut_and_vec_driver_i8 #(.NUM_VEC(256), .LATENCY(1)) dut256 (
    .clock(clock), .reset(reset), .start(start256), .a(a2), .b(b2), .y(y2),
    .busy(busy2), .done(done2), .pass(pass2), .err_count(err2), .fail_idx(fidx2)
  );

  lut_and_vec_driver_i8 #(.NUM_VEC(1), .LATENCY(0)) dut1 (
    .clock(clock), .reset(reset), .start(start1), .a(a3), .b(b3), .y(y3),
    .busy(busy3), .done(done3), .pass(pass3), .err_count(err3), .fail_idx(fidx3)
  );

  // Modelled DUTs: registered for LATENCY=1, combinational for LATENCY=0.
  always @(posedge clock) begin
    y  <= dut_resp(mode, a, b);
    y2 <= dut_resp(mode, a2, b2);
  end
  assign y3 = dut_resp(mode, a3, b3);

  // Reference timeline of the 16-vector instance: m_t counts cycles since first DRIVE.
  bit m_run = 0, m_done = 0, armed = 0;
  int m_t = 0, m_mode = 0;

  always @(posedge clock) begin
    if (reset) begin
      m_run  <= 0;
      m_done <= 0;
      m_t    <= 0;
    end else if (m_run) begin
      if (m_t == TOT - 1) begin
        m_run  <= 0;
        m_done <= 1;
      end else begin
        m_t <= m_t + 1;
      end
    end else if (start) begin
      m_run  <= 1;
      m_done <= 0;
      m_t    <= 0;
      m_mode <= mode;
    end
  end

  int cmp_k, cmp_e, cmp_f;
  // Every-cycle comparison of the 16-vector instance against the reference.
  always @(negedge clock) begin
    if (armed) begin
      chk("busy", int'(busy), int'(m_run));
      chk("done", int'(done), int'(m_done));
      if (m_run && (m_t % PER) != 0) begin
        cmp_k = m_t / PER;
        chk("vec_a", int'(a), int'(vec_a(cmp_k)));
        chk("vec_b", int'(b), int'(vec_b(cmp_k)));
      end
      if (m_done) begin
        exp_run(m_mode, NV, cmp_e, cmp_f);
        chk("err_count", int'(err_count), cmp_e);
        chk("fail_idx", int'(fail_idx), cmp_f);
        chk("pass", int'(pass), int'(cmp_e == 0));
      end
      if (!m_run && !m_done) begin
        chk("idle_a", int'(a), 0);
        chk("idle_b", int'(b), 0);
        chk("idle_err", int'(err_count), 0);
        chk("idle_pass", int'(pass), 0);
      end
    end
  end

  // One run of the 16-vector instance; optional mid-run start and reset.
  task automatic run_main(input int md, input int rst_at, input int mid_at, output int len);
    mode  = md;
    start = 1;
    @(negedge clock);
    start = 0;
    len   = -1;
    for (int t = 0; t < 200; t++) begin
      if (rst_at >= 0 && t == rst_at + 1) begin
        reset = 0;
        chk("rst_busy", int'(busy), 0);
        chk("rst_a", int'(a), 0);
        chk("rst_b", int'(b), 0);
        len = t;
        break;
      end
      if (done) begin
        len = t;
        break;
      end
`ifndef LUT_AND_VEC_LFSR_EN
      if (t == 2) begin
        chk("lit_v0_a", int'(a), 9);
        chk("lit_v0_b", int'(b), 15);
      end
      if (t == 4) begin
        chk("lit_v1_a", int'(a), 46);
        chk("lit_v1_b", int'(b), 44);
      end
`endif
      start = (t == mid_at);
      reset = (t == rst_at);
      @(negedge clock);
    end
    start = 0;
    if (len < 0) chk("main_timeout_done", int'(done), 1);
  endtask

  int len, kv, lim;

  initial begin
    repeat (3) @(negedge clock);
    reset = 0;
    armed = 1;
    repeat (3) @(negedge clock);

`ifndef LUT_AND_VEC_LFSR_EN
    kv = 1;
    chk("model_vec1_a", int'(vec_a(kv)), 46);
    chk("model_vec1_b", int'(vec_b(kv)), 44);
    kv = 5;
    chk("model_vec5_and", int'(vec_a(kv) & vec_b(kv)), 128);
`endif

    // Ideal DUT, with a start pulse in the middle that must be ignored.
    run_main(0, -1, 20, len);
    chk("ideal_len", len, TOT);
    chk("ideal_pass", int'(pass), 1);
    chk("ideal_err", int'(err_count), 0);
    repeat (2) @(negedge clock);

    // y stuck at zero, restarted from DONE.
    run_main(1, -1, -1, len);
    chk("stuck_len", len, TOT);
    chk("stuck_fidx", int'(fail_idx), 0);
    chk("stuck_pass", int'(pass), 0);

    // Single fault at vector 5.
    run_main(2, -1, -1, len);
    chk("fault5_len", len, TOT);
`ifndef LUT_AND_VEC_LFSR_EN
    chk("fault5_err", int'(err_count), 1);
    chk("fault5_fidx", int'(fail_idx), 5);
    chk("fault5_pass", int'(pass), 0);
`endif

    // Reset at cycle 10 of a run, then a clean rerun.
    run_main(0, 10, -1, len);
    repeat (2) @(negedge clock);
    chk("post_rst_done", int'(done), 0);
    run_main(0, -1, -1, len);
    chk("rerun_len", len, TOT);
    chk("rerun_pass", int'(pass), 1);

    // 256 vectors, every result inverted: saturating error count.
    mode = 3;
    start256 = 1;
    @(negedge clock);
    start256 = 0;
    len = -1;
    lim = 2000;
    for (int t = 0; t < lim; t++) begin
      if (done2) begin
        len = t;
        break;
      end
      @(negedge clock);
    end
    chk("nv256_len", len, 256 * 3);
    chk("nv256_done", int'(done2), 1);
    chk("nv256_err", int'(err2), 255);
    chk("nv256_fidx", int'(fidx2), 0);
    chk("nv256_pass", int'(pass2), 0);

    // One vector, zero latency, stuck-at-zero DUT.
    mode = 1;
    start1 = 1;
    @(negedge clock);
    start1 = 0;
    len = -1;
    for (int t = 0; t < 50; t++) begin
      if (done3) begin
        len = t;
        break;
      end
      @(negedge clock);
    end
    chk("nv1_len", len, 2);
    chk("nv1_err", int'(err3), 1);
    chk("nv1_fidx", int'(fidx3), 0);
    chk("nv1_pass", int'(pass3), 0);

    repeat (2) @(negedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
